// File: rtl/sdrc_bank_arb.sv
// Bank arbiter: locks a grant onto one bank FSM and forwards its command to xfr_ctl.
// A 4-entry rank FIFO keeps RD/WR in request order; PRE/ACT are served round-robin.
module sdrc_bank_arb #(
  parameter int REQ_ID_W = 4,
  parameter int REQ_BW   = 12
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [3:0]            i_bk_req,
  input  logic [7:0]            i_bk_cmd,
  input  logic [51:0]           i_bk_addr,
  input  logic [4*REQ_ID_W-1:0] i_bk_id,
  input  logic [4*REQ_BW-1:0]   i_bk_len,
  input  logic [3:0]            i_bk_start,
  input  logic [3:0]            i_bk_last,
  input  logic [3:0]            i_bk_wrap,
  input  logic [3:0]            i_bk_accept,
  output logic [3:0]            o_bk_ack,
  output logic                  o_x_req,
  output logic [1:0]            o_x_cmd,
  output logic [1:0]            o_x_ba,
  output logic [12:0]           o_x_addr,
  output logic [REQ_ID_W-1:0]   o_x_id,
  output logic [REQ_BW-1:0]     o_x_len,
  output logic                  o_x_start,
  output logic                  o_x_last,
  output logic                  o_x_wrap,
  input  logic                  i_x_ack,
  output logic                  o_rank_ovf
);

  typedef enum logic {ST_IDLE, ST_GRANT} state_t;

  state_t     r_state, w_state_nxt;
  logic [1:0] r_grant_bank;
  logic [1:0] r_rr_ptr;
  logic [1:0] r_rank [4];
  logic [1:0] r_wr_ptr, r_rd_ptr;
  logic [2:0] r_count;
  logic       r_rank_ovf;

  logic       w_grant_vld;
  logic [1:0] w_head;
  logic       w_head_vld;
  logic [3:0] w_rw;
  logic [3:0] w_pa_elig;
  logic       w_head_elig;
  logic       w_sel_vld;
  logic [1:0] w_sel_bank;
  logic       w_x_req;
  logic       w_ack;
  logic       w_pop;
  logic       w_acc_one;
  logic       w_acc_multi;
  logic       w_push;
  logic       w_ovf_evt;
  logic [1:0] w_acc_idx;

  assign w_grant_vld = (r_state == ST_GRANT);
  assign w_head      = r_rank[r_rd_ptr];
  assign w_head_vld  = (r_count != 3'd0);
  assign w_rw        = {i_bk_cmd[7], i_bk_cmd[5], i_bk_cmd[3], i_bk_cmd[1]};
  assign w_pa_elig   = i_bk_req & ~w_rw;
  assign w_head_elig = w_head_vld & i_bk_req[w_head] & w_rw[w_head];

  // Outputs are gated by reset_n so no request or ack escapes while reset is held.
  assign w_x_req = w_grant_vld & reset_n & i_bk_req[r_grant_bank];
  assign w_ack   = w_x_req & i_x_ack;
  assign w_pop   = w_ack & w_rw[r_grant_bank] & w_head_vld;

  assign w_acc_one   = (i_bk_accept != 4'd0) && ((i_bk_accept & (i_bk_accept - 4'd1)) == 4'd0);
  assign w_acc_multi = (i_bk_accept != 4'd0) && !w_acc_one;
  assign w_push      = w_acc_one & ((r_count != 3'd4) | w_pop);
  assign w_ovf_evt   = w_acc_multi | (w_acc_one & (r_count == 3'd4) & ~w_pop);

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    w_acc_idx = 2'd0;
    for (int i = 0; i < 4; i++)
      if (i_bk_accept[i]) w_acc_idx = 2'(i);
  end

  // Head RD/WR wins; otherwise the first PRE/ACT at or after rr_ptr.
  always_comb begin
    w_sel_vld  = 1'b0;
    w_sel_bank = r_rr_ptr;
    if (w_head_elig) begin
      w_sel_vld  = 1'b1;
      w_sel_bank = w_head;
    end else begin
      for (int i = 3; i >= 0; i--) begin
        if (w_pa_elig[r_rr_ptr + 2'(i)]) begin
          w_sel_vld  = 1'b1;
          w_sel_bank = r_rr_ptr + 2'(i);
        end
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE:  if (w_sel_vld) w_state_nxt = ST_GRANT;
      ST_GRANT: if (w_ack || !i_bk_req[r_grant_bank]) w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    o_bk_ack  = 4'd0;
    o_x_req   = 1'b0;
    o_x_cmd   = 2'd0;
    o_x_ba    = 2'd0;
    o_x_addr  = 13'd0;
    o_x_id    = '0;
    o_x_len   = '0;
    o_x_start = 1'b0;
    o_x_last  = 1'b0;
    o_x_wrap  = 1'b0;
    if (w_grant_vld && reset_n) begin
      o_x_req                = w_x_req;
      o_bk_ack[r_grant_bank] = w_ack;
      o_x_cmd                = i_bk_cmd[2*r_grant_bank +: 2];
      o_x_ba                 = r_grant_bank;
      o_x_addr               = i_bk_addr[13*r_grant_bank +: 13];
      o_x_id                 = i_bk_id[REQ_ID_W*r_grant_bank +: REQ_ID_W];
      o_x_len                = i_bk_len[REQ_BW*r_grant_bank +: REQ_BW];
      o_x_start              = i_bk_start[r_grant_bank];
      o_x_last               = i_bk_last[r_grant_bank];
      o_x_wrap               = i_bk_wrap[r_grant_bank];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_grant_bank <= 2'd0;
      r_rr_ptr     <= 2'd0;
      r_wr_ptr     <= 2'd0;
      r_rd_ptr     <= 2'd0;
      r_count      <= 3'd0;
      r_rank_ovf   <= 1'b0;
    end else begin
      if (r_state == ST_IDLE && w_sel_vld) r_grant_bank <= w_sel_bank;
      if (w_ack)     r_rr_ptr   <= r_grant_bank + 2'd1;
      if (w_push)    r_wr_ptr   <= r_wr_ptr + 2'd1;
      if (w_pop)     r_rd_ptr   <= r_rd_ptr + 2'd1;
      if (w_ovf_evt) r_rank_ovf <= 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 3'd1;
        2'b01:   r_count <= r_count - 3'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  // NOTE: FIFO storage has no reset; pointers and count alone define which entries are live.
  always_ff @(posedge clk) begin
    if (w_push) r_rank[r_wr_ptr] <= w_acc_idx;
  end

  assign o_rank_ovf = r_rank_ovf;

endmodule

// File: tb/tb_sdrc_bank_arb.sv
// Directed bench for sdrc_bank_arb: expected grants go into a scoreboard queue,
// a negedge monitor pops and compares on every bk_ack strobe.
module tb_sdrc_bank_arb;
  localparam int REQ_ID_W = 4;
  localparam int REQ_BW   = 12;

  logic                  clk = 1'b0;
  logic                  reset_n;
  logic [3:0]            bk_req, bk_start, bk_last, bk_wrap, bk_accept, bk_ack;
  logic [7:0]            bk_cmd;
  logic [51:0]           bk_addr;
  logic [4*REQ_ID_W-1:0] bk_id;
  logic [4*REQ_BW-1:0]   bk_len;
  logic                  x_req, x_start, x_last, x_wrap, x_ack, rank_ovf;
  logic [1:0]            x_cmd, x_ba;
  logic [12:0]           x_addr;
  logic [REQ_ID_W-1:0]   x_id;
  logic [REQ_BW-1:0]     x_len;

  typedef struct packed {
    logic [1:0] bank;
    logic [1:0] cmd;
  } exp_t;

  exp_t sb_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  sdrc_bank_arb #(.REQ_ID_W(REQ_ID_W), .REQ_BW(REQ_BW)) dut (
    .clk(clk), .reset_n(reset_n),
    .i_bk_req(bk_req), .i_bk_cmd(bk_cmd), .i_bk_addr(bk_addr),
    .i_bk_id(bk_id), .i_bk_len(bk_len),
    .i_bk_start(bk_start), .i_bk_last(bk_last), .i_bk_wrap(bk_wrap),
    .i_bk_accept(bk_accept), .o_bk_ack(bk_ack),
    .o_x_req(x_req), .o_x_cmd(x_cmd), .o_x_ba(x_ba), .o_x_addr(x_addr),
    .o_x_id(x_id), .o_x_len(x_len),
    .o_x_start(x_start), .o_x_last(x_last), .o_x_wrap(x_wrap),
    .i_x_ack(x_ack), .o_rank_ovf(rank_ovf)
  );

  function automatic logic [12:0] f_addr(input int n);
    return 13'h0A0 + 13'(n * 'h111);
  endfunction

  function automatic logic [REQ_ID_W-1:0] f_id(input int n);
    return REQ_ID_W'(n + 5);
  endfunction

  function automatic logic [REQ_BW-1:0] f_len(input int n);
    return REQ_BW'(16 * n + 3);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n   = 1'b0;
    bk_req    = 4'd0;
    bk_cmd    = 8'd0;
    bk_accept = 4'd0;
    x_ack     = 1'b0;
    step();
    step();
    reset_n = 1'b1;
  endtask

  // Scoreboard monitor: every ack must match the next expected grant.
  always @(negedge clk) begin
    exp_t e;
    if (bk_ack != 4'd0) begin
      if (sb_q.size() == 0) begin
        check("ack_unexpected", 32'(bk_ack), 32'd0);
      end else begin
        e = sb_q.pop_front();
        check("ack_onehot", 32'(bk_ack), 32'(4'b0001 << e.bank));
        check("ack_x_ba",   32'(x_ba),   32'(e.bank));
        check("ack_x_cmd",  32'(x_cmd),  32'(e.cmd));
        check("ack_x_addr", 32'(x_addr), 32'(f_addr(int'(e.bank))));
        check("ack_x_id",   32'(x_id),   32'(f_id(int'(e.bank))));
        check("ack_x_len",  32'(x_len),  32'(f_len(int'(e.bank))));
        check("ack_x_attr", 32'({x_start, x_last, x_wrap}),
              32'({bk_start[e.bank], bk_last[e.bank], bk_wrap[e.bank]}));
      end
    end
  end

  initial begin
    bk_start = 4'b0101;
    bk_last  = 4'b0011;
    bk_wrap  = 4'b1001;
    for (int n = 0; n < 4; n++) begin
      bk_addr[13*n +: 13]             = f_addr(n);
      bk_id[REQ_ID_W*n +: REQ_ID_W]   = f_id(n);
      bk_len[REQ_BW*n +: REQ_BW]      = f_len(n);
    end

    // Reset held with every bank requesting PRE.
    reset_n   = 1'b0;
    bk_req    = 4'hF;
    bk_cmd    = 8'd0;
    bk_accept = 4'd0;
    x_ack     = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check($sformatf("rst_x_req_%0d", i), 32'(x_req), 32'd0);
      check($sformatf("rst_bk_ack_%0d", i), 32'(bk_ack), 32'd0);
    end
    check("rst_rank_ovf", 32'(rank_ovf), 32'd0);
    step();
    reset_n = 1'b1;
    @(negedge clk);
    check("rel_idle_x_req", 32'(x_req), 32'd0);
    step();
    @(negedge clk);
    check("first_grant_x_req", 32'(x_req), 32'd1);
    check("first_grant_x_ba",  32'(x_ba),  32'd0);
    check("first_grant_x_cmd", 32'(x_cmd), 32'd0);
    // Reset asserted over a live grant with x_ack high: no ack may appear.
    step();
    reset_n = 1'b0;
    x_ack   = 1'b1;
    @(negedge clk);
    check("midrst_x_req",  32'(x_req),  32'd0);
    check("midrst_bk_ack", 32'(bk_ack), 32'd0);
    step();
    reset_n = 1'b1;
    x_ack   = 1'b0;
    bk_req  = 4'd0;
    @(negedge clk);
    check("midrst_grant_clr", 32'(dut.w_grant_vld), 32'd0);

    // Round-robin over ACT on banks 0, 1, 3.
    do_reset();
    bk_cmd = 8'h55;
    bk_req = 4'b1011;
    x_ack  = 1'b1;
    sb_q.push_back('{bank: 2'd0, cmd: 2'b01});
    sb_q.push_back('{bank: 2'd1, cmd: 2'b01});
    sb_q.push_back('{bank: 2'd3, cmd: 2'b01});
    sb_q.push_back('{bank: 2'd0, cmd: 2'b01});
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check($sformatf("rr_x_req_%0d", i), 32'(x_req), 32'(i % 2));
      step();
    end
    bk_req = 4'd0;
    x_ack  = 1'b0;

    // Rank ordering: push 2 then 1, both RD.
    do_reset();
    bk_accept = 4'b0100;
    step();
    bk_accept = 4'b0010;
    step();
    bk_accept = 4'd0;
    bk_cmd    = 8'h28;
    bk_req    = 4'b0010;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check($sformatf("ord_nonhead_%0d", i), 32'(x_req), 32'd0);
      step();
    end
    bk_req = 4'b0110;
    sb_q.push_back('{bank: 2'd2, cmd: 2'b10});
    sb_q.push_back('{bank: 2'd1, cmd: 2'b10});
    @(negedge clk);
    check("ord_select", 32'(x_req), 32'd0);
    step();
    @(negedge clk);
    check("ord_hold_x_req", 32'(x_req), 32'd1);
    check("ord_hold_x_ba",  32'(x_ba),  32'd2);
    step();
    x_ack = 1'b1;
    @(negedge clk);
    step();
    @(negedge clk);
    check("ord_gap", 32'(x_req), 32'd0);
    step();
    @(negedge clk);
    check("ord_second_x_ba", 32'(x_ba), 32'd1);
    step();
    bk_req = 4'd0;
    x_ack  = 1'b0;
    @(negedge clk);
    check("ord_count_empty", 32'(dut.r_count), 32'd0);

    // Head WR on bank 3 beats PRE on bank 0 with rr_ptr at 0.
    do_reset();
    bk_accept = 4'b1000;
    step();
    bk_accept = 4'd0;
    bk_cmd    = 8'hC0;
    bk_req    = 4'b1001;
    x_ack     = 1'b1;
    sb_q.push_back('{bank: 2'd3, cmd: 2'b11});
    sb_q.push_back('{bank: 2'd0, cmd: 2'b00});
    @(negedge clk);
    check("prio_select", 32'(x_req), 32'd0);
    step();
    @(negedge clk);
    check("prio_first_x_ba", 32'(x_ba), 32'd3);
    step();
    @(negedge clk);
    check("prio_gap", 32'(x_req), 32'd0);
    step();
    @(negedge clk);
    check("prio_second_x_ba", 32'(x_ba), 32'd0);
    step();
    bk_req = 4'd0;
    x_ack  = 1'b0;

    // Release without ack, then re-grant the same bank.
    do_reset();
    bk_cmd = 8'h04;
    bk_req = 4'b0010;
    @(negedge clk);
    step();
    @(negedge clk);
    check("rel_x_req", 32'(x_req), 32'd1);
    check("rel_x_ba",  32'(x_ba),  32'd1);
    step();
    bk_req = 4'd0;
    x_ack  = 1'b1;
    @(negedge clk);
    check("rel_drop_x_req",  32'(x_req),  32'd0);
    check("rel_drop_bk_ack", 32'(bk_ack), 32'd0);
    step();
    @(negedge clk);
    check("rel_grant_clr", 32'(dut.w_grant_vld), 32'd0);
    check("rel_rr_ptr",    32'(dut.r_rr_ptr),    32'd0);
    step();
    bk_req = 4'b0010;
    sb_q.push_back('{bank: 2'd1, cmd: 2'b01});
    @(negedge clk);
    step();
    @(negedge clk);
    step();
    bk_req = 4'd0;
    x_ack  = 1'b0;
    @(negedge clk);
    check("regrant_rr_ptr", 32'(dut.r_rr_ptr), 32'd2);

    // Overflow: fifth push into a full FIFO.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      bk_accept = 4'(1 << i);
      step();
    end
    bk_accept = 4'b0001;
    @(negedge clk);
    check("ovf_full_count", 32'(dut.r_count), 32'd4);
    check("ovf_before",     32'(rank_ovf),    32'd0);
    step();
    bk_accept = 4'd0;
    @(negedge clk);
    check("ovf_count_held", 32'(dut.r_count), 32'd4);
    check("ovf_set",        32'(rank_ovf),    32'd1);

    // Multi-hot accept: flagged, nothing pushed, flag sticky.
    do_reset();
    @(negedge clk);
    check("ovf_rst_clr", 32'(rank_ovf), 32'd0);
    bk_accept = 4'b0011;
    step();
    bk_accept = 4'd0;
    @(negedge clk);
    check("multi_ovf",   32'(rank_ovf),    32'd1);
    check("multi_count", 32'(dut.r_count), 32'd0);
    step();
    step();
    @(negedge clk);
    check("ovf_sticky", 32'(rank_ovf), 32'd1);

    step();
    check("sb_drain", 32'(sb_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sdrc_bank_arb.md
# sdrc_bank_arb

Arbiter between the four per-bank FSMs and the single transfer controller (xfr_ctl). Each bank FSM presents its next SDRAM command (PRE/ACT/RD/WR) with address and transfer attributes. This block locks a grant onto one bank, forwards that bank's command to xfr_ctl, and returns the accept strobe to the granted bank only. A 4-entry rank FIFO keeps RD/WR issue in original request order across banks; PRE/ACT may issue out of order to hide row-open latency.

## Interface
- REQ_ID_W, 4, request ID width
- REQ_BW, 12, transfer length width
- clk  in  1  clock, all state on rising edge
- reset_n  in  1  reset, synchronous, active-low
- bk_req  in  4  per-bank command request (b2x_req of bank n on bit n)
- bk_cmd  in  8  per-bank command, 2 bits per bank: 00 PRE, 01 ACT, 10 RD, 11 WR
- bk_addr  in  52  per-bank row/col address, 13 bits per bank
- bk_id  in  4*REQ_ID_W  per-bank request ID
- bk_len  in  4*REQ_BW  per-bank transfer length
- bk_start, bk_last, bk_wrap  in  4 each  per-bank burst attributes
- bk_accept  in  4  one-hot; bank n accepted a new request from req_gen (its b2r_ack); pushes n into rank FIFO
- bk_ack  out  4  one-hot command-accepted strobe to bank FSMs (x2b_ack)
- x_req  out  1  command request to xfr_ctl
- x_cmd  out  2  command
- x_ba  out  2  bank address, equals granted bank
- x_addr  out  13  row/col address
- x_id, x_len  out  REQ_ID_W, REQ_BW  forwarded attributes
- x_start, x_last, x_wrap  out  1 each  forwarded attributes
- x_ack  in  1  xfr_ctl accepted the command
- rank_ovf  out  1  sticky error: push into full FIFO or multi-hot bk_accept

## Operation
- State: grant_vld, grant_bank[1:0], rr_ptr[1:0], rank FIFO (4 x 2 bits, rd/wr pointers, 3-bit count), rank_ovf.
- Eligibility of bank n: bk_req[n] and either (cmd is PRE/ACT) or (cmd is RD/WR, count != 0, rank head == n). A RD/WR from a non-head bank is never granted.
- Selection when grant_vld=0 and any bank eligible:
  - Head bank eligible with RD/WR takes highest priority.
  - Otherwise, eligible PRE/ACT banks are served round-robin, searching from rr_ptr upward with modulo 4.
  - Select sets grant_vld=1 and grant_bank=n at the next edge.
- While grant_vld=1:
  - x_req = bk_req[grant_bank].
  - x_cmd, x_addr, x_id, x_len, x_start, x_last, x_wrap are muxed live from grant_bank's fields.
  - x_ba = grant_bank.
- Ack routing is combinational: bk_ack[grant_bank] = x_ack & x_req & grant_vld; all other bits are 0. x_ack is ignored when x_req=0.
- On ack: grant_vld clears and rr_ptr = grant_bank+1 (mod 4). If the command was RD/WR, the rank FIFO pops.
- Release without ack: if grant_vld=1 and bk_req[grant_bank]=0, grant_vld clears at the next edge. rr_ptr and FIFO are unchanged, so the bank may be re-granted later.
- Rank push: bk_accept one-hot pushes its index.
  - Simultaneous push and pop: both take effect and count is unchanged.
  - Push while count=4 with no pop in the same cycle: entry dropped, rank_ovf set.
  - Multi-hot bk_accept: no push, rank_ovf set.
  - rank_ovf clears only on reset.
- Reset mid-operation: all state clears immediately at the reset edge, including any pending grant. No bk_ack is issued during reset.

## Timing
- Reset values:
  - x_req=0, bk_ack=0, rank_ovf=0.
  - x_cmd=0, x_ba=0, x_addr=0, x_id=0, x_len=0, x_start=0, x_last=0, x_wrap=0 (all data outputs forced 0 when grant_vld=0).
  - grant_vld=0, rr_ptr=0, FIFO empty.
- Grant latency: request eligible in cycle T gives x_req=1 in cycle T+1.
- Ack at cycle T+k clears the grant at the next edge. The earliest next grant is x_req in cycle T+k+2, so the minimum spacing is 2 cycles per command.
- A push in cycle T makes that bank the rank head visible at T+1.
- A pop takes effect at the edge ending the ack cycle.

## Test plan
- Reset: with bk_req=4'hF held, assert reset_n=0 for 2 cycles -> x_req=0 and bk_ack=0 throughout; the first grant goes to bank 0 (PRE) one cycle after release.
- Round-robin: banks 0, 1 and 3 hold ACT, x_ack tied to 1 -> grant order 0, 1, 3, 0, with one x_req every 2 cycles and x_ba matching each grant.
- Rank ordering: push 2 then 1, both request RD -> bank 2 RD issues first. Bank 1 is not granted until bank 2 is acked, then bank 1 issues; count returns to 0.
- Priority: head bank 3 requests WR while bank 0 requests PRE and rr_ptr=0 -> bank 3 WR granted first, then bank 0 PRE.
- Release: grant bank 1, then drop bk_req[1] before x_ack -> grant_vld=0 the next cycle, no bk_ack, rr_ptr stays 0.
- Overflow: push 0, 1, 2, 3, then push 0 with no pop -> count stays 4 and rank_ovf=1. Separately, bk_accept=4'b0011 sets rank_ovf with no push.
